// File: rtl/cvxif_add_issue_scheduler.sv
// cvxif_add_issue_scheduler
//   In-order issue queue and execution sequencer for the CV-X-IF add example.
//   Accepted instructions wait in a NbEntries-deep circular queue until the
//   core commits or kills them. Committed entries then run one at a time on
//   an XLEN adder with ExecLatency cycles of latency, and their results are
//   returned on a valid/ready channel.
//
//   Ports
//     clk_i, rst_i                   clock, async active-high reset
//     issue_*                        issue request from the core
//     dec_accept_i/dec_writeback_i   decoder decision for the issued instr
//     issue_accept_o/_writeback_o    decision returned to the core
//     commit_*                       commit/kill strobe by id
//     result_*                       result channel (valid/ready)
//     busy_o                         any entry held or execution in flight
//
//   Optional: define CVXIF_SCHED_PERF_EN to add the perf_issued_o,
//   perf_killed_o and perf_resp_stall_o counters.
module cvxif_add_issue_scheduler #(
  parameter int unsigned NbEntries   = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IdWidth     = 3,
  parameter int unsigned ExecLatency = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [2*XLEN-1:0]  issue_rs_i,
  input  logic [1:0]         issue_rs_valid_i,
  input  logic               dec_accept_i,
  input  logic               dec_writeback_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o,
  output logic               busy_o
`ifdef CVXIF_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_issued_o,
  output logic [31:0]        perf_killed_o,
  output logic [31:0]        perf_resp_stall_o
`endif
);

  localparam int unsigned PW = $clog2(NbEntries);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = (ExecLatency > 1) ? $clog2(ExecLatency) : 1;

  typedef enum logic [2:0] {E_FREE, E_WAIT, E_READY, E_KILLED, E_EXEC} ent_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} fsm_e;

  ent_e               st_q  [NbEntries];
  logic [IdWidth-1:0] id_q  [NbEntries];
  logic [XLEN-1:0]    rs1_q [NbEntries];
  logic [XLEN-1:0]    rs2_q [NbEntries];
  logic [4:0]         rd_q  [NbEntries];
  logic               we_q  [NbEntries];

  logic [PW-1:0]      head_q, tail_q;
  logic [CW-1:0]      cnt_q;
  fsm_e               fsm_q;
  logic [LW-1:0]      lat_q;

  logic               res_valid_q, res_we_q;
  logic [IdWidth-1:0] res_id_q;
  logic [XLEN-1:0]    res_data_q;
  logic [4:0]         res_rd_q;

  logic empty, full, push, pop_kill, pop_resp, pop;
  logic unused_instr;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(NbEntries));

  // Ready is forced low while reset is asserted, even before the first edge.
  assign issue_ready_o     = !rst_i && !full && (issue_rs_valid_i == 2'b11);
  assign issue_accept_o    = issue_valid_i & dec_accept_i;
  assign issue_writeback_o = issue_valid_i & dec_writeback_i;

  assign push     = issue_valid_i && issue_ready_o && dec_accept_i;
  assign pop_kill = (fsm_q == S_IDLE) && !empty && (st_q[head_q] == E_KILLED);
  assign pop_resp = (fsm_q == S_RESP) && result_ready_i;
  assign pop      = pop_kill || pop_resp;

  assign result_valid_o = res_valid_q;
  assign result_id_o    = res_id_q;
  assign result_data_o  = res_data_q;
  assign result_rd_o    = res_rd_q;
  assign result_we_o    = res_we_q;
  assign busy_o         = !empty || (fsm_q != S_IDLE);

  assign unused_instr = ^{issue_instr_i[31:12], issue_instr_i[6:0]};

  // Later assignments win: commit updates, then enqueue (so a commit for the
  // id being enqueued lands on the new slot), then head-side FSM updates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NbEntries; i++) begin
        st_q[i]  <= E_FREE;
        id_q[i]  <= '0;
        rs1_q[i] <= '0;
        rs2_q[i] <= '0;
        rd_q[i]  <= '0;
        we_q[i]  <= 1'b0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      fsm_q       <= S_IDLE;
      lat_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_we_q    <= 1'b0;
    end else begin
      // Only WAIT entries match, so a late kill for an executing entry is dropped.
      if (commit_valid_i) begin
        for (int i = 0; i < NbEntries; i++) begin
          if (st_q[i] == E_WAIT && id_q[i] == commit_id_i)
            st_q[i] <= commit_kill_i ? E_KILLED : E_READY;
        end
      end

      if (push) begin
        id_q[tail_q]  <= issue_id_i;
        rs1_q[tail_q] <= issue_rs_i[XLEN-1:0];
        rs2_q[tail_q] <= issue_rs_i[2*XLEN-1:XLEN];
        rd_q[tail_q]  <= issue_instr_i[11:7];
        we_q[tail_q]  <= dec_writeback_i;
        if (commit_valid_i && commit_id_i == issue_id_i)
          st_q[tail_q] <= commit_kill_i ? E_KILLED : E_READY;
        else
          st_q[tail_q] <= E_WAIT;
        tail_q <= tail_q + 1'b1;
      end

      cnt_q <= cnt_q + CW'(push) - CW'(pop);

      if (pop) begin
        st_q[head_q] <= E_FREE;
        head_q       <= head_q + 1'b1;
      end

      case (fsm_q)
        S_IDLE: begin
          if (!empty && st_q[head_q] == E_READY) begin
            st_q[head_q] <= E_EXEC;
            lat_q        <= LW'(ExecLatency - 1);
            fsm_q        <= S_EXEC;
          end
        end
        // The EXEC state lasts ExecLatency cycles; the result register
        // loads on the last one so valid rises ExecLatency cycles after entry.
        S_EXEC: begin
          if (lat_q == '0) begin
            res_valid_q <= 1'b1;
            res_id_q    <= id_q[head_q];
            res_data_q  <= rs1_q[head_q] + rs2_q[head_q];
            res_rd_q    <= rd_q[head_q];
            res_we_q    <= we_q[head_q];
            fsm_q       <= S_RESP;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        S_RESP: begin
          if (result_ready_i) begin
            res_valid_q <= 1'b0;
            fsm_q       <= S_IDLE;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

`ifdef CVXIF_SCHED_PERF_EN
  logic [31:0] perf_iss_q, perf_kill_q, perf_stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_iss_q   <= '0;
      perf_kill_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push)                                  perf_iss_q   <= perf_iss_q + 1'b1;
      if (pop_kill)                              perf_kill_q  <= perf_kill_q + 1'b1;
      if (fsm_q == S_RESP && !result_ready_i)    perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_issued_o     = perf_iss_q;
  assign perf_killed_o     = perf_kill_q;
  assign perf_resp_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_cvxif_add_issue_scheduler.sv
// Scoreboarded bench for cvxif_add_issue_scheduler: directed scenarios then
// randomized issue/commit/kill/backpressure traffic. The reference model is a
// queue of issued instructions tagged waiting/committed/killed; results must
// come back in issue order for committed entries only.
module tb_cvxif_add_issue_scheduler;
  localparam int N   = 4;
  localparam int XL  = 32;
  localparam int IW  = 3;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid_i, issue_ready_o;
  logic [31:0]   issue_instr_i;
  logic [IW-1:0] issue_id_i;
  logic [2*XL-1:0] issue_rs_i;
  logic [1:0]    issue_rs_valid_i;
  logic          dec_accept_i, dec_writeback_i;
  logic          issue_accept_o, issue_writeback_o;
  logic          commit_valid_i, commit_kill_i;
  logic [IW-1:0] commit_id_i;
  logic          result_valid_o, result_ready_i, result_we_o, busy_o;
  logic [IW-1:0] result_id_o;
  logic [XL-1:0] result_data_o;
  logic [4:0]    result_rd_o;
`ifdef CVXIF_SCHED_PERF_EN
  logic [31:0]   perf_iss, perf_kill, perf_stall;
`endif

  always #5 clk = ~clk;

  cvxif_add_issue_scheduler #(.NbEntries(N), .XLEN(XL), .IdWidth(IW), .ExecLatency(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
    .dec_accept_i(dec_accept_i), .dec_writeback_i(dec_writeback_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .busy_o(busy_o)
`ifdef CVXIF_SCHED_PERF_EN
    , .perf_issued_o(perf_iss), .perf_killed_o(perf_kill), .perf_resp_stall_o(perf_stall)
`endif
  );

  // st: 0 waiting for commit, 1 committed, 2 killed
  typedef struct {
    logic [IW-1:0] id;
    logic [31:0]   rs1;
    logic [31:0]   rs2;
    logic [4:0]    rd;
    logic          we;
    int            st;
  } ent_t;

  ent_t mq[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_commit(input logic [IW-1:0] id, input logic kill);
    foreach (mq[i])
      if (mq[i].st == 0 && mq[i].id == id) mq[i].st = kill ? 2 : 1;
  endtask

  function automatic bit is_waiting(input logic [IW-1:0] id);
    foreach (mq[i])
      if (mq[i].st == 0 && mq[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  // Drives one issue cycle starting just after a rising edge.
  task automatic do_issue(input logic [IW-1:0] id, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic acc, input logic we,
                          input logic [1:0] rsv, input logic chk_rdy, input logic exp_rdy);
    logic [31:0] ins;
    ent_t e;
    ins = $urandom;
    ins[11:7] = rd;
    issue_valid_i    = 1'b1;
    issue_id_i       = id;
    issue_rs_i       = {b, a};
    issue_instr_i    = ins;
    issue_rs_valid_i = rsv;
    dec_accept_i     = acc;
    dec_writeback_i  = we;
    #1;
    chk("accept_out", issue_accept_o, acc);
    chk("writeback_out", issue_writeback_o, we);
    if (rsv != 2'b11) chk("ready_rs_invalid", issue_ready_o, 0);
    if (chk_rdy) chk("issue_ready", issue_ready_o, exp_rdy);
    if (issue_ready_o && acc) begin
      e.id = id; e.rs1 = a; e.rs2 = b; e.rd = rd; e.we = we; e.st = 0;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    issue_valid_i    = 1'b0;
    dec_accept_i     = 1'b0;
    dec_writeback_i  = 1'b0;
    issue_rs_valid_i = 2'b11;
  endtask

  task automatic do_commit(input logic [IW-1:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    model_commit(id, kill);
    tick(1);
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  // Ticks until result_valid_o, returning the number of ticks taken.
  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid_o && n < 40) begin
      tick(1);
      n++;
    end
  endtask

  // Monitor: scores every result handshake and checks outputs hold while stalled.
  initial begin
    logic          pv, pr, hwe;
    logic [IW-1:0] hid;
    logic [31:0]   hdata, sum;
    logic [4:0]    hrd;
    ent_t e;
    pv = 1'b0; pr = 1'b0;
    hid = '0; hdata = '0; hrd = '0; hwe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("hold_valid", result_valid_o, 1);
          chk("hold_payload", {result_id_o, result_data_o, result_rd_o, result_we_o},
              {hid, hdata, hrd, hwe});
        end
        if (result_valid_o && result_ready_i) begin
          hs_cnt++;
          while (mq.size() > 0 && mq[0].st == 2) void'(mq.pop_front());
          if (mq.size() == 0 || mq[0].st != 1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual_id=%0d required=no result", result_id_o);
          end else begin
            e = mq.pop_front();
            sum = e.rs1 + e.rs2;
            chk("res_id", result_id_o, e.id);
            chk("res_data", result_data_o, sum);
            chk("res_rd", result_rd_o, e.rd);
            chk("res_we", result_we_o, e.we);
          end
        end
        pv = result_valid_o; pr = result_ready_i;
        hid = result_id_o; hdata = result_data_o; hrd = result_rd_o; hwe = result_we_o;
      end
    end
  end

  initial begin
    int n, h0, pend;
    logic [IW-1:0] cid, iid;
    logic          cv, ok;
    ent_t e;

    rst = 1'b1;
    issue_valid_i = 1'b0; issue_instr_i = '0; issue_id_i = '0; issue_rs_i = '0;
    issue_rs_valid_i = 2'b11; dec_accept_i = 1'b0; dec_writeback_i = 1'b0;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
    result_ready_i = 1'b1;
    tick(2);
    chk("rst_ready", issue_ready_o, 0);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_payload", {result_id_o, result_data_o, result_rd_o, result_we_o}, 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_ready", issue_ready_o, 1);

    // Basic issue -> commit -> result with latency check.
    do_issue(3'd1, 32'd5, 32'd7, 5'd9, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    do_commit(3'd1, 1'b0);
    wait_valid(n);
    chk("exec_latency", n, LAT + 1);
    chk("basic_data", result_data_o, 32'd12);
    tick(2);

    // Fill the queue, check full, then free one slot.
    for (int i = 0; i < N; i++)
      do_issue(IW'(i), $urandom, $urandom, 5'(i + 1), 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    do_issue(3'd4, 32'd1, 32'd1, 5'd5, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    chk("full_busy", busy_o, 1);
    do_commit(3'd0, 1'b0);
    n = 0;
    while (!issue_ready_o && n < 20) begin tick(1); n++; end
    chk("ready_returns", issue_ready_o, 1);
    for (int i = 1; i < N; i++) do_commit(IW'(i), 1'b0);
    n = 0;
    while (busy_o && n < 60) begin tick(1); n++; end
    chk("drain_busy", busy_o, 0);

    // Killed head is popped in one cycle, only the committed one responds.
    do_issue(3'd2, 32'd100, 32'd23, 5'd3, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
    do_issue(3'd3, 32'd40, 32'd2, 5'd4, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    do_commit(3'd2, 1'b1);
    do_commit(3'd3, 1'b0);
    wait_valid(n);
    chk("kill_pop_latency", n, LAT + 1);
    chk("kill_result_id", result_id_o, 3);
    tick(2);

    // Carry dropped; backpressure keeps outputs stable, one handshake.
    result_ready_i = 1'b0;
    do_issue(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd31, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    do_commit(3'd5, 1'b0);
    wait_valid(n);
    chk("wrap_valid", result_valid_o, 1);
    chk("wrap_data", result_data_o, 0);
    tick(3);
    h0 = hs_cnt;
    result_ready_i = 1'b1;
    tick(4);
    chk("single_handshake", hs_cnt - h0, 1);
    chk("valid_dropped", result_valid_o, 0);

    // Rejected instruction and a commit for an absent id.
    do_issue(3'd6, 32'd1, 32'd2, 5'd1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1);
    chk("reject_busy", busy_o, 0);
    do_commit(3'd6, 1'b0);
    tick(5);
    chk("absent_commit_busy", busy_o, 0);
    chk("absent_commit_valid", result_valid_o, 0);

    // Reset while a result is pending.
    result_ready_i = 1'b0;
    do_issue(3'd7, 32'd8, 32'd9, 5'd2, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    do_commit(3'd7, 1'b0);
    wait_valid(n);
    chk("pre_rst_valid", result_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", result_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", issue_ready_o, 0);
    mq.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("postrst_busy", busy_o, 0);
    chk("postrst_ready", issue_ready_o, 1);
    result_ready_i = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      result_ready_i = ($urandom % 4) != 0;
      cv = 1'b0;
      cid = '0;
      if ($urandom % 3 == 0) begin
        pend = 0;
        foreach (mq[i]) if (mq[i].st == 0) pend++;
        if (pend > 0) begin
          n = $urandom % pend;
          foreach (mq[i])
            if (mq[i].st == 0) begin
              if (n == 0) cid = mq[i].id;
              n--;
            end
          cv = 1'b1;
        end else begin
          cid = IW'($urandom);
          cv = 1'b1;
        end
        commit_valid_i = 1'b1;
        commit_id_i    = cid;
        commit_kill_i  = ($urandom % 4) == 0;
        model_commit(cid, commit_kill_i);
      end
      if ($urandom % 2) begin
        ok = 1'b0;
        iid = '0;
        for (int t = 0; t < 100 && !ok; t++) begin
          iid = IW'($urandom);
          ok = !is_waiting(iid) && !(cv && iid == cid);
        end
        issue_valid_i    = 1'b1;
        issue_id_i       = iid;
        issue_rs_i       = {$urandom, $urandom};
        issue_instr_i    = $urandom;
        issue_rs_valid_i = ($urandom % 8 == 0) ? 2'($urandom) : 2'b11;
        dec_accept_i     = ($urandom % 5) != 0;
        dec_writeback_i  = 1'($urandom);
        #1;
        chk("rnd_accept", issue_accept_o, dec_accept_i);
        chk("rnd_writeback", issue_writeback_o, dec_writeback_i);
        if (issue_rs_valid_i != 2'b11) chk("rnd_ready_rs", issue_ready_o, 0);
        if (issue_ready_o && dec_accept_i) begin
          e.id = iid; e.rs1 = issue_rs_i[31:0]; e.rs2 = issue_rs_i[63:32];
          e.rd = issue_instr_i[11:7]; e.we = dec_writeback_i; e.st = 0;
          mq.push_back(e);
        end
      end else begin
        issue_valid_i   = 1'b0;
        dec_accept_i    = 1'($urandom);
        dec_writeback_i = 1'($urandom);
        #1;
        chk("rnd_accept_novalid", issue_accept_o, 0);
        chk("rnd_wb_novalid", issue_writeback_o, 0);
      end
      @(posedge clk);
      #1;
      issue_valid_i = 1'b0; dec_accept_i = 1'b0; dec_writeback_i = 1'b0;
      issue_rs_valid_i = 2'b11;
      commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    end

    // Drain: commit everything still waiting, then let results flow out.
    result_ready_i = 1'b1;
    for (int g = 0; g < 16; g++) begin
      ok = 1'b0;
      foreach (mq[i])
        if (!ok && mq[i].st == 0) begin
          cid = mq[i].id;
          ok = 1'b1;
        end
      if (ok) do_commit(cid, 1'b0);
    end
    n = 0;
    while (busy_o && n < 300) begin tick(1); n++; end
    tick(2);
    chk("final_busy", busy_o, 0);
    pend = 0;
    foreach (mq[i]) if (mq[i].st != 2) pend++;
    chk("final_pending", pend, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
